// File: rtl/pc_sequencer.sv
// Program counter / instruction register sequencer for the multi-cycle CPU.
// Optional PC_MISALIGN_TRAP_EN adds a TRAP state and a misalign output for unaligned next-PC.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      ir,
   output logic             ir_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             pc_commit,
   input  logic [1:0]       pc_src,
   input  logic             branch_take,
   input  logic [31:0]      rs_val,
   input  logic             halt,
`ifdef PC_MISALIGN_TRAP_EN
   output logic             misalign,
`endif
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

`ifdef PC_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {S_RST, S_FETCH, S_HOLD, S_HALT, S_TRAP} state_t;
`else
   typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD, S_HALT} state_t;
`endif

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic             ir_valid_q, ir_valid_d;
   logic             imem_req_q, imem_req_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [31:0]      next_pc;
   logic [31:0]      br_off;
`ifdef PC_MISALIGN_TRAP_EN
   logic             misalign_q, misalign_d;
`endif

   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         2'b01:   next_pc = branch_take ? (pc_plus4 + br_off) : pc_plus4;
         2'b10:   next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
         2'b11:   next_pc = rs_val;
         default: next_pc = pc_plus4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      imem_req_d = imem_req_q;
      halted_d   = halted_q;
      retired_d  = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         S_RST: begin
            state_d    = S_FETCH;
            imem_req_d = 1'b1;
         end
         S_FETCH: begin
            if (imem_ready) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               imem_req_d = 1'b0;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (pc_commit) begin
               pc_d       = next_pc;
               retired_d  = retired_q + CNT_W'(1);
               ir_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
               // Misalignment wins over halt so the fault is always visible.
               if (next_pc[1:0] != 2'b00) begin
                  state_d    = S_TRAP;
                  halted_d   = 1'b1;
                  misalign_d = 1'b1;
               end else
`endif
               if (halt) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d    = S_FETCH;
                  imem_req_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RST;
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         ir_valid_q <= 1'b0;
         imem_req_q <= 1'b0;
         halted_q   <= 1'b0;
         retired_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         imem_req_q <= imem_req_d;
         halted_q   <= halted_d;
         retired_q  <= retired_d;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign imem_req  = imem_req_q;
   assign halted    = halted_q;
   assign retired   = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
   assign misalign  = misalign_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter (PC) and instruction register (IR) of the multi-cycle CPU.
- Sequences instruction fetch through a request/ready handshake with instruction memory.
- Holds the fetched instruction until the main control FSM signals commit, then computes and writes the next PC.
- Next-PC sources: sequential, taken branch, J-type jump target {PC+4[31:28], instr_index, 2'b00}, and register jump (jr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_ready  input  1  instruction memory has valid data on imem_rdata this cycle.
- imem_addr  output  32  fetch address; always equals pc.
- imem_rdata  input  32  fetched instruction word.
- ir  output  32  instruction register.
- ir_valid  output  1  IR holds an instruction awaiting commit.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, mod 2^32.
- pc_commit  input  1  one-cycle pulse from main control: instruction finished, update PC.
- pc_src  input  2  00 sequential, 01 branch, 10 jump, 11 register jump.
- branch_take  input  1  branch condition result; sampled with pc_commit.
- rs_val  input  32  register value for jr; sampled with pc_commit.
- halt  input  1  stop after the current commit.
- halted  output  1  sequencer is stopped.
- retired  output  CNT_W  count of committed instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): state=RST, pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, halted=0, retired=0.
- States: RST, FETCH, HOLD, HALT (TRAP only when the optional feature is enabled).
- RST -> FETCH unconditionally on the first clock edge after reset release.
- FETCH: imem_req=1.
  - On an edge where imem_ready=1: ir<=imem_rdata, state->HOLD.
  - ir_valid=1 from the next cycle onward.
  - imem_ready=0: remain in FETCH with no time limit; pc and ir unchanged.
- HOLD: imem_req=0, ir_valid=1.
  - On an edge where pc_commit=1: pc<=next_pc, retired<=retired+1 (wraps at 2^CNT_W), ir_valid<=0.
  - Then state->HALT if halt=1, else state->FETCH.
  - Fetch of the new PC begins the cycle after commit, so commit-to-imem_req latency is 1 cycle.
- next_pc, computed combinationally from ir and pc_plus4:
  - 00, or 01 with branch_take=0: pc_plus4.
  - 01 with branch_take=1: pc_plus4 + ({{14{ir[15]}}, ir[15:0], 2'b00}), mod 2^32.
  - 10: {pc_plus4[31:28], ir[25:0], 2'b00}.
  - 11: rs_val, unmodified.
- pc_commit outside HOLD (in RST, FETCH or HALT) is ignored; no PC or counter change.
- halt outside a commit edge has no effect. halt together with pc_commit still applies that commit.
- HALT: imem_req=0, ir_valid=0, halted=1; pc and retired frozen. Only reset exits.
- imem_ready outside FETCH is ignored.
- Reset mid-fetch or mid-hold: immediate return to reset values; any outstanding request is abandoned.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - At a commit whose next_pc[1:0]!=0, pc is still written with next_pc, retired increments, and state->TRAP.
  - TRAP: imem_req=0, ir_valid=0, halted=1, and extra output port misalign=1.
  - pc holds the faulting address. Only reset exits TRAP.
  - misalign resets to 0.
- Not defined:
  - No misalign port and no TRAP state.
  - next_pc[1:0] passes through unchanged and is fetched as-is.

Test Plan:
- Reset/fetch: release rst_n, imem_ready=1 after 3 cycles with rdata=0x20080005 -> imem_req high in FETCH with imem_addr=0x00000000; ir=0x20080005 and ir_valid=1 the cycle after ready.
- Sequential: pc=0x00000000, commit with pc_src=00 -> pc=0x00000004, retired=1, imem_req=1 the next cycle.
- Jump: pc=0xA0000010, ir=0x08000040, commit with pc_src=10 -> pc=0xA0000100.
- Branch: pc=0x00000100, ir[15:0]=0xFFFF, pc_src=01:
  - branch_take=1 -> pc=0x00000100.
  - repeated with branch_take=0 -> pc=0x00000104.
- Register jump and halt: pc_src=11, rs_val=0x00400020, halt=1 at commit -> pc=0x00400020, halted=1, imem_req remains 0 thereafter.
- Stray commit and misalign (PC_MISALIGN_TRAP_EN): pc_commit pulsed during FETCH -> no change. Then commit with pc_src=11, rs_val=0x00000203 -> pc=0x00000203, misalign=1, halted=1.
